// File: rtl/sms_trigger_bank.sv
// sms_trigger_bank: bank of N set/reset triggers with DC forcing and pulse-gated AC/binary inputs.
//   clk            system clock, all state changes on the rising edge
//   rst            synchronous active-high reset: q cleared, history loaded from live inputs
//   dc_set_n       low-true DC set per trigger
//   dc_reset_n     low-true DC reset per trigger, overrides DC set
//   ac_set_pulse   AC set line, acts on its falling edge when ac_set_gate was high last clock
//   ac_set_gate    high-true conditioning gate for AC set
//   ac_reset_pulse AC reset line, acts on its falling edge when ac_reset_gate was high last clock
//   ac_reset_gate  high-true conditioning gate for AC reset
//   bin_pulse      toggle line, acts on its falling edge
//   q, q_n         trigger state and its complement
module sms_trigger_bank #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] dc_set_n,
    input  logic [N-1:0] dc_reset_n,
    input  logic [N-1:0] ac_set_pulse,
    input  logic [N-1:0] ac_set_gate,
    input  logic [N-1:0] ac_reset_pulse,
    input  logic [N-1:0] ac_reset_gate,
    input  logic [N-1:0] bin_pulse,
    output logic [N-1:0] q,
    output logic [N-1:0] q_n
);
    // Card pull-ups: only a driven 0 (or an unknown) reads low; 1 and floating z read high.
    function automatic logic [N-1:0] res(input logic [N-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = ~((v[i] === 1'b0) | (v[i] === 1'bx));
        return r;
    endfunction

    logic [N-1:0] ds, dr, sp, sg, rp, rg, bp;
    logic [N-1:0] set_h, rst_h, bin_h, sg_h, rg_h;
    logic [N-1:0] se, re, be, tog, ac, q_nx;

    assign ds = res(dc_set_n);
    assign dr = res(dc_reset_n);
    assign sp = res(ac_set_pulse);
    assign sg = res(ac_set_gate);
    assign rp = res(ac_reset_pulse);
    assign rg = res(ac_reset_gate);
    assign bp = res(bin_pulse);

    // Gates are qualified by last cycle's value to model gate setup time.
    assign se = set_h & ~sp & sg_h;
    assign re = rst_h & ~rp & rg_h;
    assign be = bin_h & ~bp;
    // Set+reset together toggles; a binary edge with anything toggles once.
    assign tog = (se & re) | be;
    assign ac = (tog & ~q) | (~tog & (se | (~re & q)));
    // DC reset dominates DC set; both dominate (and discard) AC events.
    assign q_nx = dr & (~ds | ac);
    assign q_n = ~q;

    always_ff @(posedge clk) begin
        set_h <= sp;
        rst_h <= rp;
        bin_h <= bp;
        sg_h  <= sg;
        rg_h  <= rg;
        q     <= rst ? '0 : q_nx;
    end
endmodule
